mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 10, RAM word-address width.
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on its rising edge.
- rst, in, 1, asynchronous active-low reset.
- if_req, in, 1, fetch request; held stable until accepted.
- if_addr, in, 32, fetch byte address.
- if_stall, out, 1, fetch not accepted this cycle.
- if_valid, out, 1, fetch response pulse.
- if_rdata, out, 32, fetched instruction.
- dm_req, in, 1, data request; held stable until accepted.
- dm_we, in, 1, 1 = store, 0 = load.
- dm_size, in, 2, 00 = byte, 01 = half, 10 = word.
- dm_unsigned, in, 1, zero-extend loads.
- dm_addr, in, 32, data byte address.
- dm_wdata, in, 32, store data, right-justified.
- dm_stall, out, 1, data not accepted this cycle.
- dm_valid, out, 1, data response pulse (loads and stores).
- dm_err, out, 1, misaligned access; qualified by dm_valid.
- dm_rdata, out, 32, extended load data.
- ram_ena, out, 1, RAM enable.
- ram_wea, out, 4, RAM byte write enables.
- ram_addra, out, ADDR_W, RAM word address.
- ram_dina, out, 32, RAM write data.
- ram_douta, in, 32, RAM read data; 1-cycle latency.

Function
REQ-003 SHALL grant at most one requester per cycle, combinationally. Data wins unless streak == MAX_STREAK with if_req high, in which case fetch wins.
REQ-004 SHALL drive if_stall = if_req & ~fetch_grant and dm_stall = dm_req & ~data_grant, combinationally.
REQ-005 SHALL maintain the streak counter: +1 on each data grant while if_req=1; cleared on a fetch grant or whenever if_req=0; saturates at MAX_STREAK.
REQ-006 SHALL on a grant drive ram_ena=1 and ram_addra = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap.
REQ-007 SHALL track the outstanding access in a state machine: IDLE -> RD_I (fetch granted) or RD_D (data granted). From any state, go to RD_I, RD_D, or IDLE according to the next cycle's grant. Back-to-back grants issue every cycle.
REQ-008 SHALL assert if_valid or dm_valid exactly one cycle after the corresponding grant.
REQ-009 SHALL register if_rdata from ram_douta when in RD_I and hold it until the next fetch response. dm_rdata SHALL follow the same rule in RD_D.
REQ-010 SHALL steer stores as follows:
- byte: ram_wea = 0001 << addr[1:0], ram_dina = {4{wdata[7:0]}}.
- half: ram_wea = addr[1] ? 1100 : 0011, ram_dina = {2{wdata[15:0]}}.
- word: ram_wea = 1111, ram_dina = wdata.
REQ-011 SHALL extract loads by lane using the registered addr[1:0], size and unsigned flags: sign-extend, or zero-extend when dm_unsigned=1. dm_size=11 SHALL be treated as word.
REQ-012 SHALL treat a misaligned access (half with addr[0]=1; word with addr[1:0]!=0) as follows: grant it, keep ram_ena=0 and ram_wea=0, then one cycle later pulse dm_valid with dm_err=1 and leave dm_rdata unchanged.
REQ-013 SHALL give a store a dm_valid pulse one cycle after its grant, with dm_rdata unchanged.
REQ-014 SHALL drive ram_wea=0 whenever the access is not a granted, aligned store.

Reset
REQ-015 SHALL, while rst=0, asynchronously force: state IDLE, streak 0, if_valid=dm_valid=dm_err=0, if_rdata=dm_rdata=0. RAM outputs SHALL be gated to 0 (ram_ena=0, ram_wea=0).
REQ-016 SHALL drop an access in flight when reset is asserted: no valid pulse after release. The first grant is possible in the first cycle with rst=1.

Structure
REQ-017 SHALL place the shared definitions in package mem_arb_pkg: size encodings (SZ_B, SZ_H, SZ_W), the state enum (IDLE, RD_I, RD_D) and default parameter constants.
REQ-018 SHALL implement store lane steering and load extraction/extension as the combinational sub-module mem_lane_align, with the arbiter FSM in the top.

Verification
REQ-019 Fetch alone: if_req=1, if_addr=0x10, RAM word 4=0x00500093 -> if_stall=0; next cycle if_valid=1, if_rdata=0x00500093.
REQ-020 Contention: if_req=dm_req=1 for 6 cycles -> 4 data grants, then 1 fetch grant, then data again; if_stall=1 in the first 4 cycles.
REQ-021 Byte store/load: sb 0xAB at 0x103, then lb at 0x103 -> ram_wea=1000; lb returns 0xFFFFFFAB; lbu returns 0x000000AB.
REQ-022 Half store: sh 0x8001 at 0x102 -> ram_wea=1100, ram_dina=0x80018001; lh from 0x102 -> 0xFFFF8001.
REQ-023 Misaligned: lw at 0x101 -> ram_ena=0; next cycle dm_valid=1, dm_err=1.
REQ-024 Reset mid-read: fetch granted, rst=0 the following cycle -> if_valid stays 0, if_rdata=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the access-size encodings, the arbiter state enum, the default
// parameter values and a small alignment helper used by the top level.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_MAX_STREAK = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_I = 2'b01,
        RD_D = 2'b10
    } arbState_e;

    // Size 11 is handled like a word, so it also needs 4-byte alignment.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_B:    isMisaligned = 1'b0;
            SZ_H:    isMisaligned = addrLo[0];
            default: isMisaligned = (addrLo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-port RAM signals.
// slave  : the arbiter side (takes requests and RAM read data, drives
//          stalls, responses and the RAM command).
// master : the requesters/RAM side, the mirror image of slave.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_stall;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic              dm_unsigned;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_stall;
    logic              dm_valid;
    logic              dm_err;
    logic [31:0]       dm_rdata;

    logic              ram_ena;
    logic [3:0]        ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [31:0]       ram_dina;
    logic [31:0]       ram_douta;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
        input  ram_douta,
        output if_stall, if_valid, if_rdata,
        output dm_stall, dm_valid, dm_err, dm_rdata,
        output ram_ena, ram_wea, ram_addra, ram_dina
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
        output ram_douta,
        input  if_stall, if_valid, if_rdata,
        input  dm_stall, dm_valid, dm_err, dm_rdata,
        input  ram_ena, ram_wea, ram_addra, ram_dina
    );

endinterface

// File: rtl/mem_lane_align.sv
// Purely combinational byte-lane steering for the data port.
// Store side: stSize_i/stAddr_i/stWdata_i -> byte enables stWea_o and
//             replicated write data stDina_o.
// Load side : ldSize_i/ldAddr_i/ldUnsigned_i/ldRaw_i -> extracted and
//             sign- or zero-extended ldData_o.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  stSize_i,
    input  logic [1:0]  stAddr_i,
    input  logic [31:0] stWdata_i,
    output logic [3:0]  stWea_o,
    output logic [31:0] stDina_o,
    input  logic [1:0]  ldSize_i,
    input  logic [1:0]  ldAddr_i,
    input  logic        ldUnsigned_i,
    input  logic [31:0] ldRaw_i,
    output logic [31:0] ldData_o
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Replicate the right-justified store data across every lane so the
    // byte enables alone decide which RAM bytes change.
    always_comb begin
        stWea_o  = 4'b1111;
        stDina_o = stWdata_i;
        case (stSize_i)
            SZ_B: begin
                stWea_o  = 4'b0001 << stAddr_i;
                stDina_o = {4{stWdata_i[7:0]}};
            end
            SZ_H: begin
                stWea_o  = stAddr_i[1] ? 4'b1100 : 4'b0011;
                stDina_o = {2{stWdata_i[15:0]}};
            end
            default: begin
                stWea_o  = 4'b1111;
                stDina_o = stWdata_i;
            end
        endcase
    end

    // Pick the addressed lane out of the RAM word, then extend it.
    always_comb begin
        ldByte   = ldRaw_i[{ldAddr_i, 3'b000} +: 8];
        ldHalf   = ldAddr_i[1] ? ldRaw_i[31:16] : ldRaw_i[15:0];
        ldData_o = ldRaw_i;
        case (ldSize_i)
            SZ_B:    ldData_o = {{24{~ldUnsigned_i & ldByte[7]}}, ldByte};
            SZ_H:    ldData_o = {{16{~ldUnsigned_i & ldHalf[15]}}, ldHalf};
            default: ldData_o = ldRaw_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM with
// one-cycle read latency. Data normally wins; after MAX_STREAK data grants
// with a fetch waiting, the fetch is served.
// Ports: clk  - rising-edge clock
//        rst  - asynchronous active-low reset
//        bus  - mem_arbiter_if.slave (fetch port, data port, RAM command)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_STREAK = DEF_MAX_STREAK
)(
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.slave   bus
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    arbState_e           state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [1:0]          ldAddr_q, ldSize_q;
    logic                ldUnsigned_q, ldLoad_q, dmErr_q;
    logic [31:0]         ifRdata_q, ifRdata_d;
    logic [31:0]         dmRdata_q, dmRdata_d;

    logic                fetchGrant, dataGrant, dmMis;
    logic [3:0]          stWea;
    logic [31:0]         stDina, ldData;

    // Address bits above the RAM window and below the word boundary are
    // intentionally dropped: addresses simply wrap.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.dm_addr[31:ADDR_W+2]};

    mem_lane_align u_lane (
        .stSize_i     (bus.dm_size),
        .stAddr_i     (bus.dm_addr[1:0]),
        .stWdata_i    (bus.dm_wdata),
        .stWea_o      (stWea),
        .stDina_o     (stDina),
        .ldSize_i     (ldSize_q),
        .ldAddr_i     (ldAddr_q),
        .ldUnsigned_i (ldUnsigned_q),
        .ldRaw_i      (bus.ram_douta),
        .ldData_o     (ldData)
    );

    // Grant decision; nothing is granted while reset is held so the RAM
    // command stays quiet.
    always_comb begin
        fetchGrant = rst & bus.if_req & (~bus.dm_req | (streak_q == STREAK_MAX));
        dataGrant  = rst & bus.dm_req & ~fetchGrant;
        dmMis      = isMisaligned(bus.dm_size, bus.dm_addr[1:0]);
    end

    // Next state follows whichever grant is issued this cycle; the streak
    // only counts data grants that made a fetch wait.
    always_comb begin
        state_d  = IDLE;
        streak_d = streak_q;
        if (fetchGrant) begin
            state_d = RD_I;
        end else if (dataGrant) begin
            state_d = RD_D;
        end
        if (fetchGrant || !bus.if_req) begin
            streak_d = '0;
        end else if (dataGrant && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // RAM command and responses. Read data bypasses straight from the RAM
    // in the response cycle and is then held in the _q registers.
    always_comb begin
        bus.if_stall  = bus.if_req & ~fetchGrant;
        bus.dm_stall  = bus.dm_req & ~dataGrant;
        bus.ram_ena   = fetchGrant | (dataGrant & ~dmMis);
        bus.ram_addra = '0;
        if (fetchGrant) begin
            bus.ram_addra = bus.if_addr[ADDR_W+1:2];
        end else if (dataGrant) begin
            bus.ram_addra = bus.dm_addr[ADDR_W+1:2];
        end
        bus.ram_wea   = (dataGrant & bus.dm_we & ~dmMis) ? stWea : 4'b0000;
        bus.ram_dina  = (dataGrant & bus.dm_we) ? stDina : 32'h0;
        bus.if_valid  = (state_q == RD_I);
        bus.dm_valid  = (state_q == RD_D);
        bus.dm_err    = (state_q == RD_D) & dmErr_q;
        bus.if_rdata  = (state_q == RD_I) ? bus.ram_douta : ifRdata_q;
        bus.dm_rdata  = (state_q == RD_D && ldLoad_q) ? ldData : dmRdata_q;
        ifRdata_d     = bus.if_rdata;
        dmRdata_d     = bus.dm_rdata;
    end

    // State, streak and the attributes of the data access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            ldAddr_q     <= 2'b00;
            ldSize_q     <= SZ_B;
            ldUnsigned_q <= 1'b0;
            ldLoad_q     <= 1'b0;
            dmErr_q      <= 1'b0;
            ifRdata_q    <= 32'h0;
            dmRdata_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            ifRdata_q <= ifRdata_d;
            dmRdata_q <= dmRdata_d;
            if (dataGrant) begin
                ldAddr_q     <= bus.dm_addr[1:0];
                ldSize_q     <= bus.dm_size;
                ldUnsigned_q <= bus.dm_unsigned;
                ldLoad_q     <= ~bus.dm_we & ~dmMis;
                dmErr_q      <= dmMis;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a byte-addressed model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 10;
    localparam int MAXS = 4;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .MAX_STREAK(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ramArr [0:(1<<AW)-1];
    logic [7:0]  refMem [0:(4<<AW)-1];

    // Reference model state
    int          mStreak = 0;
    int          mPend = 0;
    int          mBytes, mA, mIa, mLane;
    logic        mFg, mDg, mMis, mEna, mPendErr, mPendStore;
    logic [3:0]  mWea;
    logic [31:0] mPendData, mLastIf, mLastDm, mV;
    logic        ifAcc, dmAcc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with registered read data
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            bus.ram_douta <= ramArr[bus.ram_addra];
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_wea[b]) ramArr[bus.ram_addra][8*b +: 8] <= bus.ram_dina[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] w);
        ramArr[idx] <= w;
        for (int b = 0; b < 4; b++) refMem[idx*4 + b] = w[8*b +: 8];
    endtask

    function automatic int byteCount(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    task automatic applyStimulus(input logic r, input logic ifr, input logic [31:0] ifa,
                                 input logic dr, input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] da, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst             = r;
        bus.if_req      = ifr;
        bus.if_addr     = ifa;
        bus.dm_req      = dr;
        bus.dm_we       = we;
        bus.dm_size     = sz;
        bus.dm_unsigned = uns;
        bus.dm_addr     = da;
        bus.dm_wdata    = wd;
    endtask

    // Compare process: every falling edge, check outputs against the model
    // and then advance the model past the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rstIfValid", 32'(bus.if_valid), 32'h0);
            checkOutput("rstDmValid", 32'(bus.dm_valid), 32'h0);
            checkOutput("rstIfRdata", bus.if_rdata, 32'h0);
            checkOutput("rstDmRdata", bus.dm_rdata, 32'h0);
            checkOutput("rstRamEna", 32'(bus.ram_ena), 32'h0);
            checkOutput("rstRamWea", 32'(bus.ram_wea), 32'h0);
            mStreak = 0;
            mPend   = 0;
            mLastIf = 32'h0;
            mLastDm = 32'h0;
        end else begin
            if (mPend == 1) mLastIf = mPendData;
            if (mPend == 2 && !mPendErr && !mPendStore) mLastDm = mPendData;
            checkOutput("ifValid", 32'(bus.if_valid), 32'(mPend == 1));
            checkOutput("dmValid", 32'(bus.dm_valid), 32'(mPend == 2));
            checkOutput("ifRdata", bus.if_rdata, mLastIf);
            checkOutput("dmRdata", bus.dm_rdata, mLastDm);
            if (mPend == 2) checkOutput("dmErr", 32'(bus.dm_err), 32'(mPendErr));

            mFg = bus.if_req && (!bus.dm_req || mStreak == MAXS);
            mDg = bus.dm_req && !mFg;
            checkOutput("ifStall", 32'(bus.if_stall), 32'(bus.if_req && !mFg));
            checkOutput("dmStall", 32'(bus.dm_stall), 32'(bus.dm_req && !mDg));

            mBytes = byteCount(bus.dm_size);
            mA     = int'(bus.dm_addr[AW+1:0]);
            mMis   = (mA % mBytes) != 0;
            mEna   = mFg || (mDg && !mMis);
            checkOutput("ramEna", 32'(bus.ram_ena), 32'(mEna));
            if (mFg) checkOutput("ramAddrFetch", 32'(bus.ram_addra), 32'(bus.if_addr[AW+1:2]));
            else if (mEna) checkOutput("ramAddrData", 32'(bus.ram_addra), 32'(bus.dm_addr[AW+1:2]));

            mWea = 4'b0000;
            if (mDg && bus.dm_we && !mMis) begin
                for (int k = 0; k < mBytes; k++) begin
                    mLane = (mA + k) % 4;
                    mWea[mLane] = 1'b1;
                    checkOutput("ramDinaLane", 32'(bus.ram_dina[8*mLane +: 8]), 32'(bus.dm_wdata[8*k +: 8]));
                    refMem[mA + k] = bus.dm_wdata[8*k +: 8];
                end
            end
            checkOutput("ramWea", 32'(mWea), 32'(bus.ram_wea));

            mPend = 0;
            if (mFg) begin
                mPend     = 1;
                mIa       = int'(bus.if_addr[AW+1:2]) * 4;
                mPendData = {refMem[mIa+3], refMem[mIa+2], refMem[mIa+1], refMem[mIa]};
            end else if (mDg) begin
                mPend      = 2;
                mPendErr   = mMis;
                mPendStore = bus.dm_we;
                mV         = 32'h0;
                if (!mMis) begin
                    for (int k = 0; k < mBytes; k++) mV[8*k +: 8] = refMem[mA + k];
                end
                if (!bus.dm_unsigned && mBytes == 1 && mV[7])  mV = mV | 32'hFFFF_FF00;
                if (!bus.dm_unsigned && mBytes == 2 && mV[15]) mV = mV | 32'hFFFF_0000;
                mPendData  = mV;
            end

            if (mFg || !bus.if_req) mStreak = 0;
            else if (mDg && mStreak < MAXS) mStreak = mStreak + 1;
        end
    end

    initial begin
        rst             = 1'b0;
        bus.if_req      = 1'b0;
        bus.if_addr     = 32'h0;
        bus.dm_req      = 1'b0;
        bus.dm_we       = 1'b0;
        bus.dm_size     = SZ_W;
        bus.dm_unsigned = 1'b0;
        bus.dm_addr     = 32'h0;
        bus.dm_wdata    = 32'h0;
        for (int i = 0; i < (1 << AW); i++) setWord(i, $urandom());
        setWord(4, 32'h0050_0093);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetIfValid", 32'(bus.if_valid), 32'h0);
        checkOutput("resetIfRdata", bus.if_rdata, 32'h0);
        checkOutput("resetDmRdata", bus.dm_rdata, 32'h0);
        checkOutput("resetRamEna", 32'(bus.ram_ena), 32'h0);

        // Fetch alone, issued in the first cycle out of reset
        applyStimulus(1, 1, 32'h10, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("fetchStall", 32'(bus.if_stall), 32'h0);
        checkOutput("fetchRamEna", 32'(bus.ram_ena), 32'h1);
        checkOutput("fetchRamAddr", 32'(bus.ram_addra), 32'h4);
        applyStimulus(1, 0, 32'h0, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("fetchValid", 32'(bus.if_valid), 32'h1);
        checkOutput("fetchRdata", bus.if_rdata, 32'h0050_0093);

        // Contention: four data grants, one fetch, then data again
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 32'h20, 1, 0, SZ_W, 0, 32'h200, 32'h0);
            @(negedge clk); #1;
            checkOutput("contendDmStall", 32'(bus.dm_stall), 32'(i == 4));
            checkOutput("contendIfStall", 32'(bus.if_stall), 32'(i != 4));
        end

        // Byte store then signed/unsigned byte loads
        applyStimulus(1, 0, 32'h0, 1, 1, SZ_B, 0, 32'h103, 32'hAB);
        @(negedge clk); #1;
        checkOutput("sbWea", 32'(bus.ram_wea), 32'h8);
        checkOutput("sbDina", bus.ram_dina, 32'hABAB_ABAB);
        applyStimulus(1, 0, 32'h0, 1, 0, SZ_B, 0, 32'h103, 32'h0);
        @(negedge clk); #1;
        checkOutput("sbValid", 32'(bus.dm_valid), 32'h1);
        checkOutput("sbErr", 32'(bus.dm_err), 32'h0);
        applyStimulus(1, 0, 32'h0, 1, 0, SZ_B, 1, 32'h103, 32'h0);
        @(negedge clk); #1;
        checkOutput("lbData", bus.dm_rdata, 32'hFFFF_FFAB);

        // Half store, then signed half load
        applyStimulus(1, 0, 32'h0, 1, 1, SZ_H, 0, 32'h102, 32'h8001);
        @(negedge clk); #1;
        checkOutput("lbuData", bus.dm_rdata, 32'h0000_00AB);
        checkOutput("shWea", 32'(bus.ram_wea), 32'hC);
        checkOutput("shDina", bus.ram_dina, 32'h8001_8001);
        applyStimulus(1, 0, 32'h0, 1, 0, SZ_H, 0, 32'h102, 32'h0);
        @(negedge clk); #1;
        checkOutput("shKeepsRdata", bus.dm_rdata, 32'h0000_00AB);

        // Misaligned word load
        applyStimulus(1, 0, 32'h0, 1, 0, SZ_W, 0, 32'h101, 32'h0);
        @(negedge clk); #1;
        checkOutput("lhData", bus.dm_rdata, 32'hFFFF_8001);
        checkOutput("misRamEna", 32'(bus.ram_ena), 32'h0);
        checkOutput("misStall", 32'(bus.dm_stall), 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("misValid", 32'(bus.dm_valid), 32'h1);
        checkOutput("misErr", 32'(bus.dm_err), 32'h1);
        checkOutput("misKeepsRdata", bus.dm_rdata, 32'hFFFF_8001);

        // Reset while a fetch is in flight
        applyStimulus(1, 1, 32'h10, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("midFetchStall", 32'(bus.if_stall), 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("midRstValid", 32'(bus.if_valid), 32'h0);
        checkOutput("midRstRdata", bus.if_rdata, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        @(negedge clk); #1;
        checkOutput("afterRstValid", 32'(bus.if_valid), 32'h0);

        // Randomized traffic; requests stay stable until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            ifAcc = rst && bus.if_req && !bus.if_stall;
            dmAcc = rst && bus.dm_req && !bus.dm_stall;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 99) != 0);
            if (!bus.if_req || ifAcc) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = $urandom();
            end
            if (!bus.dm_req || dmAcc) begin
                bus.dm_req      = ($urandom_range(0, 2) != 0);
                bus.dm_we       = 1'($urandom_range(0, 1));
                bus.dm_size     = 2'($urandom_range(0, 3));
                bus.dm_unsigned = 1'($urandom_range(0, 1));
                bus.dm_addr     = $urandom() & 32'hFFFF_F03F;
                bus.dm_wdata    = $urandom();
            end
        end

        applyStimulus(1, 0, 32'h0, 0, 0, SZ_W, 0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
